// File: rtl/binary_decoder_pulse_gen_if.sv
// binary_decoder_pulse_gen_if: code handshake and decoded one-hot outputs.
// Parity pins exist only when DEC_PARITY_EN is defined.
interface binary_decoder_pulse_gen_if;
    logic [3:0]  binary_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] decoder_out;
    logic        out_active;
    logic        done;
`ifdef DEC_PARITY_EN
    logic        parity_in;
    logic        parity_err;
    modport master (output binary_in, in_valid, parity_in,
                    input in_ready, decoder_out, out_active, done, parity_err);
    modport slave (input binary_in, in_valid, parity_in,
                   output in_ready, decoder_out, out_active, done, parity_err);
`else
    modport master (output binary_in, in_valid,
                    input in_ready, decoder_out, out_active, done);
    modport slave (input binary_in, in_valid,
                   output in_ready, decoder_out, out_active, done);
`endif
endinterface

// File: rtl/binary_decoder_pulse_gen.sv
// binary_decoder_pulse_gen: 4-to-16 decoder emitting a timed one-hot pulse plus guard gap.
// Optional even-parity check on accepted codes when DEC_PARITY_EN is defined.
module binary_decoder_pulse_gen #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int CNT_W     = 8
) (
    input logic                       clk,
    input logic                       reset,
    input logic                       enable,
    binary_decoder_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      dec_q, dec_d;
    logic             act_q, act_d;
    logic             done_q, done_d;
    logic             accept, code_ok;
`ifdef DEC_PARITY_EN
    logic             perr_q, perr_d;
    assign code_ok        = ~(bus.parity_in ^ (^bus.binary_in));
    assign perr_d         = accept && !code_ok;
    assign bus.parity_err = perr_q;
`else
    assign code_ok = 1'b1;
`endif
    assign bus.in_ready    = (state_q == IDLE) && enable;
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.decoder_out = dec_q;
    assign bus.out_active  = act_q;
    assign bus.done        = done_q;
    // Dropping enable wins over everything, including a pulse finishing on this edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            dec_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (accept && code_ok) begin
                    dec_d   = 16'h0001 << bus.binary_in;
                    cnt_d   = CNT_W'(PULSE_LEN - 1);
                    state_d = DRIVE;
                end
                DRIVE: if (cnt_q == '0) begin
                    dec_d   = '0;
                    done_d  = 1'b1;
                    cnt_d   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
                    state_d = (GAP_LEN > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                GAP: begin
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? IDLE : GAP;
                end
                default: state_d = IDLE;
            endcase
        end
        act_d = |dec_d;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end
`ifdef DEC_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
`endif
endmodule
